// File: rtl/f6_avalon_verin_ctrl.sv
// F6 actuator controller: double-buffered PWM, serial ADC angle acquisition, hardware end stops.
// Optional macro F6_VERIN_AVG_EN: ANGLE reports the mean of the last four conversions.
module f6_avalon_verin_ctrl #(
    parameter int PWM_WIDTH   = 16,
    parameter int ADC_BITS    = 12,
    parameter int ADC_CLK_DIV = 25,
    parameter int ADC_GAP     = 50
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        out_pwm,
    output logic        out_sens,
    output logic        clk_adc,
    output logic        cs_n,
    input  logic        data_in
);

    localparam int EW = $clog2(ADC_BITS + 4);
    localparam int DW = (ADC_CLK_DIV > 1) ? $clog2(ADC_CLK_DIV) : 1;
    localparam int GW = (ADC_GAP > 1) ? $clog2(ADC_GAP) : 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(ADC_BITS + 3);
    localparam logic [EW-1:0] SKIP_EDGES = EW'(3);
    localparam logic [EW-1:0] EDGE_ONE = EW'(1);
    localparam logic [DW-1:0] DIV_END = DW'(ADC_CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [GW-1:0] GAP_END = GW'(ADC_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    localparam logic [PWM_WIDTH-1:0] PWM_ONE = PWM_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_FRAME,
        S_LATCH
    } adc_state_t;

    adc_state_t state, state_nx;

    logic [PWM_WIDTH-1:0] freq_sh, duty_sh, freq_act, duty_act, cnt;
    logic                 pwm_en, sens, adc_en;
    logic [ADC_BITS-1:0]  butee_min, butee_max, angle, shift;
    logic                 valid, limit_hit;
    logic [DW-1:0]        div_cnt;
    logic [GW-1:0]        gap_cnt;
    logic [EW-1:0]        edge_cnt;
    logic [31:0]          rd_mux;
    logic                 unused_wd;

    logic wr_freq, wr_duty, wr_ctrl, wr_min, wr_max, wr_stat;
    logic pwm_run, wrap, at_min, at_max, block, adc_busy;
    logic div_hit, rise, gap_done, frame_done;

    assign unused_wd = ^avs_writedata;

    assign wr_freq = avs_write && (avs_address == 3'd0);
    assign wr_duty = avs_write && (avs_address == 3'd1);
    assign wr_ctrl = avs_write && (avs_address == 3'd2);
    assign wr_min  = avs_write && (avs_address == 3'd4);
    assign wr_max  = avs_write && (avs_address == 3'd5);
    assign wr_stat = avs_write && (avs_address == 3'd6);

    assign pwm_run = pwm_en && (freq_act != '0);
    assign wrap    = pwm_run && (cnt >= freq_act - PWM_ONE);

    assign at_min = valid && (angle <= butee_min);
    assign at_max = valid && (angle >= butee_max);
    assign block  = sens ? at_max : at_min;

    assign adc_busy   = (state == S_FRAME) || (state == S_LATCH);
    assign div_hit    = (div_cnt == DIV_END);
    assign rise       = (state == S_FRAME) && div_hit && !clk_adc;
    assign gap_done   = (gap_cnt == GAP_END);
    assign frame_done = (state == S_FRAME) && div_hit && clk_adc
                        && (edge_cnt == LAST_EDGE);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            freq_sh   <= '0;
            duty_sh   <= '0;
            pwm_en    <= 1'b0;
            sens      <= 1'b0;
            adc_en    <= 1'b0;
            butee_min <= '0;
            butee_max <= '1;
            limit_hit <= 1'b0;
        end else begin
            if (wr_freq) freq_sh <= avs_writedata[PWM_WIDTH-1:0];
            if (wr_duty) duty_sh <= avs_writedata[PWM_WIDTH-1:0];
            if (wr_ctrl) begin
                pwm_en <= avs_writedata[0];
                sens   <= avs_writedata[1];
                adc_en <= avs_writedata[2];
            end
            if (wr_min) butee_min <= avs_writedata[ADC_BITS-1:0];
            if (wr_max) butee_max <= avs_writedata[ADC_BITS-1:0];
            // A new hit outranks a simultaneous clear
            if (block && pwm_en)
                limit_hit <= 1'b1;
            else if (wr_stat && avs_writedata[3])
                limit_hit <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            freq_act <= '0;
            duty_act <= '0;
            cnt      <= '0;
            out_pwm  <= 1'b0;
            out_sens <= 1'b0;
        end else begin
            if (!pwm_run || wrap) begin
                freq_act <= freq_sh;
                duty_act <= duty_sh;
                cnt      <= '0;
            end else begin
                cnt <= cnt + PWM_ONE;
            end
            out_pwm  <= pwm_run && (cnt < duty_act) && !block;
            out_sens <= sens;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= S_IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (adc_en) state_nx = S_GAP;
            S_GAP:   if (gap_done) state_nx = adc_en ? S_FRAME : S_IDLE;
            S_FRAME: if (frame_done) state_nx = S_LATCH;
            S_LATCH: state_nx = adc_en ? S_GAP : S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cs_n     <= 1'b1;
            clk_adc  <= 1'b0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            edge_cnt <= '0;
            shift    <= '0;
        end else begin
            cs_n    <= (state_nx != S_FRAME);
            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_ONE : '0;
            if (state == S_FRAME) begin
                if (div_hit) begin
                    div_cnt <= '0;
                    clk_adc <= !clk_adc;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
                // First three rising edges carry the sample and null bits
                if (rise) begin
                    edge_cnt <= edge_cnt + EDGE_ONE;
                    if (edge_cnt >= SKIP_EDGES)
                        shift <= {shift[ADC_BITS-2:0], data_in};
                end
            end else begin
                div_cnt  <= '0;
                clk_adc  <= 1'b0;
                edge_cnt <= '0;
            end
        end
    end

`ifdef F6_VERIN_AVG_EN
    logic [3:0][ADC_BITS-1:0] hist;
    logic [ADC_BITS+1:0]      acc, acc_nx;
    logic [2:0]               n_conv;
    logic                     adc_en_q;

    // Running sum: add the newest sample, drop the one leaving the window
    assign acc_nx = acc + {2'b00, shift} - {2'b00, hist[3]};

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hist     <= '0;
            acc      <= '0;
            n_conv   <= '0;
            adc_en_q <= 1'b0;
            angle    <= '0;
            valid    <= 1'b0;
        end else begin
            adc_en_q <= adc_en;
            if (adc_en && !adc_en_q) begin
                hist   <= '0;
                acc    <= '0;
                n_conv <= '0;
                valid  <= 1'b0;
            end else if (state == S_LATCH) begin
                hist   <= {hist[2:0], shift};
                acc    <= acc_nx;
                n_conv <= (n_conv == 3'd4) ? n_conv : n_conv + 3'd1;
                angle  <= acc_nx[ADC_BITS+1:2];
                valid  <= (n_conv >= 3'd3);
            end
        end
    end
`else
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            angle <= '0;
            valid <= 1'b0;
        end else if (state == S_LATCH) begin
            angle <= shift;
            valid <= 1'b1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0: rd_mux[PWM_WIDTH-1:0] = freq_sh;
            3'd1: rd_mux[PWM_WIDTH-1:0] = duty_sh;
            3'd2: rd_mux[2:0] = {adc_en, sens, pwm_en};
            3'd3: begin
                rd_mux[ADC_BITS-1:0] = angle;
                rd_mux[31]           = valid;
            end
            3'd4: rd_mux[ADC_BITS-1:0] = butee_min;
            3'd5: rd_mux[ADC_BITS-1:0] = butee_max;
            3'd6: rd_mux[3:0] = {limit_hit, adc_busy, at_max, at_min};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) avs_readdata <= '0;
        else             avs_readdata <= avs_read ? rd_mux : '0;
    end

endmodule
